// File: rtl/stream_header_framer.sv
// stream_header_framer
//   Buffers an input sample stream in a small FIFO, forwards complete frames
//   (FRAME_START .. FRAME_END) and appends a header after every frame:
//   HEADER_START, HEADER_WORDS x HEADER, HEADER_END. The header carries the
//   frame count, the FRAME_START timestamp and the pixel count.
//
//   dtype codes (dtypes.v):
//     FRAME_START 0x10, FRAME_END 0x20, HEADER_START 0x40, HEADER 0x50,
//     HEADER_END 0x60, pixel types are any code with a bit in mask 0x0F.
//
// Ports
//   clki        in   clock, rising edge
//   reset       in   synchronous active-high reset
//   enable      in   frame-aligned capture enable
//   dvi         in   input valid
//   dtypei      in   input dtype
//   datai       in   input data
//   dvo         out  output valid
//   dtypeo      out  output dtype
//   datao       out  output data
//   overflow    out  sticky: a sample was dropped on a full FIFO
//   frame_count out  number of HEADER_END words emitted
module stream_header_framer #(
    parameter int unsigned STREAM_DATA_WIDTH = 16,
    parameter int unsigned HEADER_WORDS      = 16,
    parameter int unsigned FIFO_DEPTH_LOG2   = 3,
    parameter int unsigned DTYPE_WIDTH       = 8
) (
    input  logic                         clki,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         dvi,
    input  logic [DTYPE_WIDTH-1:0]       dtypei,
    input  logic [STREAM_DATA_WIDTH-1:0] datai,
    output logic                         dvo,
    output logic [DTYPE_WIDTH-1:0]       dtypeo,
    output logic [STREAM_DATA_WIDTH-1:0] datao,
    output logic                         overflow,
    output logic [31:0]                  frame_count
);

    localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned ENTRY_W = DTYPE_WIDTH + STREAM_DATA_WIDTH;
    localparam int unsigned CNT_W   = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned WIDX_W  = (HEADER_WORDS > 1) ? $clog2(HEADER_WORDS) : 1;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = DTYPE_WIDTH'(8'h10);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = DTYPE_WIDTH'(8'h20);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = DTYPE_WIDTH'(8'h40);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = DTYPE_WIDTH'(8'h50);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_END   = DTYPE_WIDTH'(8'h60);
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = DTYPE_WIDTH'(8'h0F);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_HDR_START,
        ST_HDR_DATA,
        ST_HDR_END
    } state_t;

    state_t                       state;
    logic [WIDX_W-1:0]            word_idx;
    logic [31:0]                  ts_counter;
    logic [31:0]                  timestamp;
    logic [31:0]                  pixel_count;

    logic [ENTRY_W-1:0]           mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr;
    logic [CNT_W-1:0]             count;

    logic                         fifo_full_c;
    logic                         fifo_empty_c;
    logic                         wr_en_c;
    logic                         rd_en_c;
    logic [DTYPE_WIDTH-1:0]       head_dtype_c;
    logic [STREAM_DATA_WIDTH-1:0] head_data_c;
    logic [STREAM_DATA_WIDTH-1:0] hdr_word_c;

    // Full/empty come from the registered count, so a sample written this
    // cycle is popped no earlier than the next one.
    assign fifo_full_c  = (count == CNT_W'(DEPTH));
    assign fifo_empty_c = (count == '0);
    assign wr_en_c      = dvi && !fifo_full_c;
    assign rd_en_c      = ((state == ST_IDLE) || (state == ST_FRAME)) && !fifo_empty_c;
    assign {head_dtype_c, head_data_c} = mem[rd_ptr];

    // FIFO storage
    always_ff @(posedge clki) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= {dtypei, datai};
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clki) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (rd_en_c) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
            end
            case ({wr_en_c, rd_en_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            if (dvi && fifo_full_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // Header payload word for the current word index; unused words are zero
    always_comb begin
        hdr_word_c = '0;
        if (STREAM_DATA_WIDTH == 32) begin
            case (word_idx)
                WIDX_W'(0): hdr_word_c = STREAM_DATA_WIDTH'(frame_count);
                WIDX_W'(1): hdr_word_c = STREAM_DATA_WIDTH'(timestamp);
                WIDX_W'(2): hdr_word_c = STREAM_DATA_WIDTH'(pixel_count);
                default:    hdr_word_c = '0;
            endcase
        end else begin
            case (word_idx)
                WIDX_W'(0): hdr_word_c = STREAM_DATA_WIDTH'(frame_count[15:0]);
                WIDX_W'(1): hdr_word_c = STREAM_DATA_WIDTH'(frame_count[31:16]);
                WIDX_W'(2): hdr_word_c = STREAM_DATA_WIDTH'(timestamp[15:0]);
                WIDX_W'(3): hdr_word_c = STREAM_DATA_WIDTH'(timestamp[31:16]);
                WIDX_W'(4): hdr_word_c = STREAM_DATA_WIDTH'(pixel_count[15:0]);
                WIDX_W'(5): hdr_word_c = STREAM_DATA_WIDTH'(pixel_count[31:16]);
                default:    hdr_word_c = '0;
            endcase
        end
    end

    // Framing FSM with registered stream outputs
    always_ff @(posedge clki) begin
        if (reset) begin
            state       <= ST_IDLE;
            dvo         <= 1'b0;
            dtypeo      <= '0;
            datao       <= '0;
            frame_count <= '0;
            ts_counter  <= '0;
            timestamp   <= '0;
            pixel_count <= '0;
            word_idx    <= '0;
        end else begin
            ts_counter <= ts_counter + 32'd1;
            dvo        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Everything is discarded until an enabled FRAME_START
                    if (rd_en_c && enable && (head_dtype_c == DTYPE_FRAME_START)) begin
                        state       <= ST_FRAME;
                        dvo         <= 1'b1;
                        dtypeo      <= head_dtype_c;
                        datao       <= head_data_c;
                        timestamp   <= ts_counter;
                        pixel_count <= '0;
                    end
                end
                ST_FRAME: begin
                    // enable is ignored here so a frame is never truncated
                    if (rd_en_c) begin
                        dvo    <= 1'b1;
                        dtypeo <= head_dtype_c;
                        datao  <= head_data_c;
                        if (head_dtype_c == DTYPE_FRAME_START) begin
                            timestamp   <= ts_counter;
                            pixel_count <= '0;
                        end else if (head_dtype_c == DTYPE_FRAME_END) begin
                            state <= ST_HDR_START;
                        end else if (|(head_dtype_c & DTYPE_PIXEL_MASK)) begin
                            pixel_count <= pixel_count + 32'd1;
                        end
                    end
                end
                ST_HDR_START: begin
                    dvo      <= 1'b1;
                    dtypeo   <= DTYPE_HEADER_START;
                    datao    <= '0;
                    word_idx <= '0;
                    state    <= ST_HDR_DATA;
                end
                ST_HDR_DATA: begin
                    dvo      <= 1'b1;
                    dtypeo   <= DTYPE_HEADER;
                    datao    <= hdr_word_c;
                    word_idx <= word_idx + WIDX_W'(1);
                    if (word_idx == WIDX_W'(HEADER_WORDS - 1)) begin
                        state <= ST_HDR_END;
                    end
                end
                ST_HDR_END: begin
                    dvo         <= 1'b1;
                    dtypeo      <= DTYPE_HEADER_END;
                    datao       <= '0;
                    frame_count <= frame_count + 32'd1;
                    state       <= enable ? ST_FRAME : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
